// File: rtl/result_mem_wb_pkg.sv
// Shared types and helpers for the result write-back block.
package result_mem_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of one assembled output line.
  function automatic int unsigned line_width(input int unsigned n_macs, input int unsigned data_w);
    return n_macs * data_w;
  endfunction

  // Round half up, arithmetic right shift by frac_w, then clamp to a signed data_w range.
  // Evaluated at 65 bits so the rounding add can never overflow for accumulators up to 64 bits.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int unsigned frac_w,
                                                   input int unsigned data_w);
    logic signed [64:0] sum;
    logic signed [64:0] q;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sum = 65'(acc) + (65'sd1 <<< (frac_w - 1));
    q   = sum >>> frac_w;
    hi  = (65'sd1 <<< (data_w - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (data_w - 1));
    if (q > hi) begin
      q = hi;
    end else if (q < lo) begin
      q = lo;
    end
    return 64'(q);
  endfunction

endpackage

// File: rtl/result_mem_wb_if.sv
// Per-lane result strobes and accumulator data leaving the systolic array.
interface result_mem_wb_if #(
  parameter int unsigned N_MACS = 4,
  parameter int unsigned ACC_W  = 32
);
  logic [N_MACS-1:0]       res_valid;
  logic [N_MACS*ACC_W-1:0] res_data;

  modport master (output res_valid, output res_data);
  modport slave  (input  res_valid, input  res_data);
endinterface

// File: rtl/result_mem_wb_quant.sv
// One lane of quantisation: round, shift and saturate an accumulator to the stored width.
module result_quant
  import result_mem_wb_pkg::*;
#(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] q
);

  // Purely combinational round + saturate of a signed accumulator.
  always_comb begin
    q = DATA_W'(sat_round(64'(signed'(acc)), FRAC_W, DATA_W));
  end

endmodule

// File: rtl/result_mem_wb.sv
// Write-back end of the systolic datapath: gathers skewed lane results into lines,
// commits them to a result memory and offers a registered readback port.
module result_mem_wb
  import result_mem_wb_pkg::*;
#(
  parameter int unsigned N_MACS      = 4,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FRAC_W      = 8,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned LAYER_LINES = 16,
  parameter              DUMP_FILE   = "",
  localparam int unsigned AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int unsigned LINE_W     = line_width(N_MACS, DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  result_mem_wb_if.slave    res,
  output logic              busy,
  output logic              layer_done,
  output logic              err_ovf,
  output logic              err_idle,
  output logic [AW-1:0]     wr_addr,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [LINE_W-1:0] rd_data
);

  localparam int unsigned CW = $clog2(LAYER_LINES + 1);

  state_t            state;
  logic [N_MACS-1:0] mask;
  logic [LINE_W-1:0] stage;
  logic [LINE_W-1:0] q_line;
  logic [LINE_W-1:0] line;
  logic [CW-1:0]     line_cnt;
  logic [AW-1:0]     next_addr;
  logic              commit;
  logic              ovf_hit;
  logic              last_line;
  logic [LINE_W-1:0] mem [MEM_DEPTH];

  for (genvar i = 0; i < N_MACS; i++) begin : g_lane
    result_quant #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_quant (
      .acc (res.res_data[i*ACC_W +: ACC_W]),
      .q   (q_line[i*DATA_W +: DATA_W])
    );
  end

  // Line assembly: lanes already staged keep their first value, the rest come straight from this cycle.
  always_comb begin
    line = '0;
    for (int unsigned i = 0; i < N_MACS; i++) begin
      line[i*DATA_W +: DATA_W] = mask[i] ? stage[i*DATA_W +: DATA_W] : q_line[i*DATA_W +: DATA_W];
    end
    commit    = (state == RUN) && (&(mask | res.res_valid));
    ovf_hit   = (state == RUN) && (|(res.res_valid & mask)) && !commit;
    last_line = (line_cnt == CW'(LAYER_LINES - 1));
    next_addr = (wr_addr == AW'(MEM_DEPTH - 1)) ? '0 : wr_addr + 1'b1;
  end

  // Control FSM with lane collection, address/line counters and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      layer_done <= 1'b0;
      err_ovf    <= 1'b0;
      err_idle   <= 1'b0;
      wr_addr    <= '0;
      line_cnt   <= '0;
      mask       <= '0;
      stage      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            wr_addr  <= '0;
            line_cnt <= '0;
            mask     <= '0;
            err_ovf  <= 1'b0;
            err_idle <= 1'b0;
          end else if (|res.res_valid) begin
            err_idle <= 1'b1;
          end
        end
        RUN: begin
          if (commit) begin
            mask     <= '0;
            wr_addr  <= next_addr;
            line_cnt <= line_cnt + 1'b1;
            if (last_line) begin
              state      <= DONE;
              busy       <= 1'b0;
              layer_done <= 1'b1;
            end
          end else begin
            for (int unsigned i = 0; i < N_MACS; i++) begin
              if (res.res_valid[i] && !mask[i]) begin
                stage[i*DATA_W +: DATA_W] <= q_line[i*DATA_W +: DATA_W];
                mask[i]                   <= 1'b1;
              end
            end
            if (ovf_hit) begin
              err_ovf <= 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          layer_done <= 1'b0;
          if (|res.res_valid) begin
            err_idle <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Result memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[wr_addr] <= line;
    end
  end

  // Registered readback; a same-cycle write to the read address is seen on a later read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
